// File: rtl/subsistema_multiplicacion_booth_if.sv
// Operand/result handshake bundle for the Booth multiplier.
// master = operand producer / result consumer, slave = multiplier.
// Optional port modoSinSigno exists only when MULT_MODO_SIN_SIGNO_EN is defined.
interface subsistema_multiplicacion_booth_if #(
  parameter int ANCHO = 4
);
  logic [ANCHO-1:0]   operandoA;
  logic [ANCHO-1:0]   operandoB;
  logic               banderaValida;
  logic               banderaOcupado;
  logic [2*ANCHO-1:0] resultado;
  logic               banderaLista;
  logic               banderaAceptado;
`ifdef MULT_MODO_SIN_SIGNO_EN
  logic               modoSinSigno;

  modport master (
    output operandoA, operandoB, banderaValida, banderaAceptado, modoSinSigno,
    input  banderaOcupado, resultado, banderaLista
  );
  modport slave (
    input  operandoA, operandoB, banderaValida, banderaAceptado, modoSinSigno,
    output banderaOcupado, resultado, banderaLista
  );
`else
  modport master (
    output operandoA, operandoB, banderaValida, banderaAceptado,
    input  banderaOcupado, resultado, banderaLista
  );
  modport slave (
    input  operandoA, operandoB, banderaValida, banderaAceptado,
    output banderaOcupado, resultado, banderaLista
  );
`endif
endinterface

// File: rtl/subsistema_multiplicacion_booth.sv
// Iterative radix-2 Booth multiplier, one add/sub + arithmetic shift per cycle.
// Operands are widened to ANCHO+1 bits so the same datapath handles signed
// and unsigned products; ANCHO+1 iterations give the exact 2*ANCHO product.
// Macro MULT_MODO_SIN_SIGNO_EN: enables bus.modoSinSigno (1 = unsigned,
// sampled on the accept edge). Without it the unit is always signed.
module subsistema_multiplicacion_booth #(
  parameter int ANCHO = 4
) (
  input  logic                            reloj,
  input  logic                            reinicio,
  subsistema_multiplicacion_booth_if.slave bus
);

  localparam int CW = $clog2(ANCHO + 2);

  localparam logic [1:0] INACTIVO = 2'd0;
  localparam logic [1:0] CALCULA  = 2'd1;
  localparam logic [1:0] LISTO    = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ANCHO:0]     M_q, M_d;
  logic [ANCHO:0]     HQ_q, HQ_d;
  logic [ANCHO:0]     LQ_q, LQ_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      contador_q, contador_d;
  logic [2*ANCHO-1:0] resultado_q, resultado_d;
  logic               lista_q, lista_d;

  logic               con_signo;
  logic [ANCHO:0]     a_ext, b_ext;
  logic [ANCHO:0]     hq_sum, hq_sh, lq_sh;

  // Operand widening: sign bit replicated only in signed mode
  always_comb begin
`ifdef MULT_MODO_SIN_SIGNO_EN
    con_signo = ~bus.modoSinSigno;
`else
    con_signo = 1'b1;
`endif
    a_ext = {con_signo & bus.operandoA[ANCHO-1], bus.operandoA};
    b_ext = {con_signo & bus.operandoB[ANCHO-1], bus.operandoB};
  end

  // One Booth step: recode {LQ[0],Q_1}, then arithmetic shift {HQ,LQ,Q_1} right
  always_comb begin
    case ({LQ_q[0], q1_q})
      2'b01:   hq_sum = HQ_q + M_q;
      2'b10:   hq_sum = HQ_q - M_q;
      default: hq_sum = HQ_q;
    endcase
    hq_sh = {hq_sum[ANCHO], hq_sum[ANCHO:1]};
    lq_sh = {hq_sum[0], LQ_q[ANCHO:1]};
  end

  // Control FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    M_d         = M_q;
    HQ_d        = HQ_q;
    LQ_d        = LQ_q;
    q1_d        = q1_q;
    contador_d  = contador_q;
    resultado_d = resultado_q;
    lista_d     = lista_q;
    case (state_q)
      INACTIVO: begin
        if (bus.banderaValida) begin
          M_d        = a_ext;
          LQ_d       = b_ext;
          HQ_d       = '0;
          q1_d       = 1'b0;
          contador_d = CW'(ANCHO + 1);
          state_d    = CALCULA;
        end
      end
      CALCULA: begin
        HQ_d       = hq_sh;
        LQ_d       = lq_sh;
        q1_d       = LQ_q[0];
        contador_d = contador_q - CW'(1);
        if (contador_q == CW'(1)) begin
          // Upper two bits of {HQ,LQ} are pure sign/zero extension
          resultado_d = {hq_sh[ANCHO-2:0], lq_sh};
          lista_d     = 1'b1;
          state_d     = LISTO;
        end
      end
      LISTO: begin
        // Valid is ignored here; resultado keeps its value after release
        if (bus.banderaAceptado) begin
          lista_d = 1'b0;
          state_d = INACTIVO;
        end
      end
      default: state_d = INACTIVO;
    endcase
  end

  // State registers; reset discards any operation in flight
  always_ff @(posedge reloj or negedge reinicio) begin
    if (!reinicio) begin
      state_q     <= INACTIVO;
      M_q         <= '0;
      HQ_q        <= '0;
      LQ_q        <= '0;
      q1_q        <= 1'b0;
      contador_q  <= '0;
      resultado_q <= '0;
      lista_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      M_q         <= M_d;
      HQ_q        <= HQ_d;
      LQ_q        <= LQ_d;
      q1_q        <= q1_d;
      contador_q  <= contador_d;
      resultado_q <= resultado_d;
      lista_q     <= lista_d;
    end
  end

  assign bus.resultado      = resultado_q;
  assign bus.banderaLista   = lista_q;
  assign bus.banderaOcupado = (state_q != INACTIVO);

endmodule
